ahb3lite_req_master: RTL and testbench

Single-port AHB3-Lite master that converts a local valid/ready request stream into pipelined AHB3-Lite single transfers and returns one response per request. It is the initiator for AHB3-Lite slaves such as the on-chip SRAM, and is used by DMA engines, boot loaders and test harnesses. Address and data phases overlap, so back-to-back requests sustain one transfer per cycle. HREADY wait states and the two-cycle ERROR response are handled.

---
 rtl/ahb3lite_req_master.sv | 138 +++++++++++++
 tb/tb_ahb3lite_req_master.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb3lite_req_master.sv
// AHB3-Lite single-transfer master fed by a valid/ready request stream.
// Define AHB3LITE_REQ_MASTER_SEQ_EN to emit INCR bursts with SEQ beats.
module ahb3lite_req_master #(
    parameter int          HADDR_SIZE = 32,
    parameter int          HDATA_SIZE = 32,
    parameter logic [3:0]  HPROT_VAL  = 4'b0011
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [HADDR_SIZE-1:0] req_addr,
    input  logic [2:0]            req_size,
    input  logic [HDATA_SIZE-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [HDATA_SIZE-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  idle,
    output logic [HADDR_SIZE-1:0] HADDR,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic [1:0]            HTRANS,
    output logic [HDATA_SIZE-1:0] HWDATA,
    output logic                  HMASTLOCK,
    input  logic [HDATA_SIZE-1:0] HRDATA,
    input  logic                  HREADY,
    input  logic                  HRESP
);

    typedef enum logic [1:0] {
        TR_IDLE   = 2'b00,
        TR_BUSY   = 2'b01,
        TR_NONSEQ = 2'b10,
        TR_SEQ    = 2'b11
    } htrans_t;

    logic                  ap_valid;
    logic                  ap_cancel;
    logic [HADDR_SIZE-1:0] ap_addr;
    logic [2:0]            ap_size;
    logic                  ap_write;
    logic [HDATA_SIZE-1:0] ap_wdata;

    logic                  dp_valid;
    logic                  dp_cancel;
    logic                  dp_write;
    logic [HDATA_SIZE-1:0] dp_wdata;

    logic accept;
    logic err_first;
    logic rd_take;
    logic seq_next;
    logic ap_seq;

    assign req_ready = ~HRESET & ~ap_cancel & (~ap_valid | HREADY);
    assign accept    = req_valid & req_ready;
    assign err_first = dp_valid & HRESP & ~HREADY;
    assign rd_take   = HREADY & dp_valid & ~dp_cancel & ~dp_write & ~HRESP;

`ifdef AHB3LITE_REQ_MASTER_SEQ_EN
    logic [HADDR_SIZE-1:0] ap_step;

    // SEQ only when this request directly continues the live address phase
    always_comb begin
        ap_step  = {{(HADDR_SIZE-1){1'b0}}, 1'b1} << ap_size;
        seq_next = ap_valid & ~ap_cancel
                 & (req_write == ap_write)
                 & (req_size == ap_size)
                 & (req_addr == ap_addr + ap_step)
                 & (req_addr[HADDR_SIZE-1:10] == ap_addr[HADDR_SIZE-1:10]);
    end

    assign HBURST = ap_valid ? 3'b001 : 3'b000;
`else
    assign seq_next = 1'b0;
    assign HBURST   = 3'b000;
`endif

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            ap_valid  <= 1'b0;
            ap_cancel <= 1'b0;
            ap_seq    <= 1'b0;
            ap_addr   <= '0;
            ap_size   <= 3'b000;
            ap_write  <= 1'b0;
            ap_wdata  <= '0;
            dp_valid  <= 1'b0;
            dp_cancel <= 1'b0;
            dp_write  <= 1'b0;
            dp_wdata  <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            if (HREADY) begin
                dp_valid  <= ap_valid;
                dp_cancel <= ap_cancel;
                dp_write  <= ap_write;
                dp_wdata  <= ap_wdata;
                ap_valid  <= accept;
                ap_cancel <= 1'b0;
                ap_seq    <= accept & seq_next;
                if (accept) begin
                    ap_addr  <= req_addr;
                    ap_size  <= req_size;
                    ap_write <= req_write;
                    ap_wdata <= req_wdata;
                end
            end else if (err_first) begin
                // follower must be dropped before the second ERROR cycle
                ap_cancel <= ap_cancel | ap_valid;
            end
            rsp_valid <= HREADY & dp_valid;
            rsp_err   <= HREADY & dp_valid & (HRESP | dp_cancel);
            rsp_rdata <= rd_take ? HRDATA : '0;
        end
    end

    always_comb begin
        HTRANS = TR_IDLE;
        if (ap_valid && !ap_cancel) begin
            HTRANS = ap_seq ? TR_SEQ : TR_NONSEQ;
        end
    end

    assign HADDR     = ap_addr;
    assign HWRITE    = ap_write;
    assign HSIZE     = ap_size;
    assign HPROT     = HPROT_VAL;
    assign HWDATA    = dp_wdata;
    assign HMASTLOCK = 1'b0;
    assign idle      = ~ap_valid & ~dp_valid;

endmodule

// File: tb/tb_ahb3lite_req_master.sv
// Bench for ahb3lite_req_master: behavioural AHB slave, response scoreboard,
// vector table plus hand-timed wait/error/reset/boundary sequences.
module tb_ahb3lite_req_master;

`ifdef AHB3LITE_REQ_MASTER_SEQ_EN
    localparam bit SEQ_BUILD = 1'b1;
`else
    localparam bit SEQ_BUILD = 1'b0;
`endif
    localparam logic [2:0] EXP_BURST = SEQ_BUILD ? 3'b001 : 3'b000;

    logic        HCLK;
    logic        HRESET;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [2:0]  req_size;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        idle;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic [31:0] HWDATA;
    logic        HMASTLOCK;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    ahb3lite_req_master dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_size  (req_size),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .idle      (idle),
        .HADDR     (HADDR),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HBURST    (HBURST),
        .HPROT     (HPROT),
        .HTRANS    (HTRANS),
        .HWDATA    (HWDATA),
        .HMASTLOCK (HMASTLOCK),
        .HRDATA    (HRDATA),
        .HREADY    (HREADY),
        .HRESP     (HRESP)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge HCLK) cyc++;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask

    // ---------------- behavioural slave ----------------
    logic [31:0] mem [256];
    bit          mem_init = 1'b0;
    logic        s_valid, s_write, s_err, s_errph;
    logic [31:0] s_addr;
    int          s_wait;
    logic [31:0] wait_addr = 32'hFFFF_FFFF;
    int          wait_cnt  = 0;
    logic [31:0] err_addr  = 32'hFFFF_FFFF;
    int          seen104   = 0;

    always_comb begin
        HREADY = 1'b1;
        HRESP  = 1'b0;
        if (s_valid) begin
            if (s_wait > 0) begin
                HREADY = 1'b0;
            end else if (s_err) begin
                HREADY = s_errph;
                HRESP  = 1'b1;
            end
        end
    end

    assign HRDATA = (s_valid && !s_write) ? mem[s_addr[9:2]] : 32'h0;

    always @(posedge HCLK) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | i;
            mem[16]  <= 32'hDEAD_BEEF;
            mem_init <= 1'b1;
        end
        if (HREADY && HTRANS[1] && HADDR == 32'h104) seen104 <= seen104 + 1;
        if (HRESET) begin
            s_valid <= 1'b0;
            s_err   <= 1'b0;
            s_errph <= 1'b0;
            s_wait  <= 0;
            s_write <= 1'b0;
            s_addr  <= 32'h0;
        end else if (HREADY) begin
            if (s_valid && s_write && !s_err) mem[s_addr[9:2]] <= HWDATA;
            s_valid <= HTRANS[1];
            s_addr  <= HADDR;
            s_write <= HWRITE;
            s_wait  <= (HTRANS[1] && HADDR == wait_addr) ? wait_cnt : 0;
            s_err   <= HTRANS[1] && HADDR == err_addr;
            s_errph <= 1'b0;
        end else if (s_wait > 0) begin
            s_wait <= s_wait - 1;
        end else begin
            s_errph <= 1'b1;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic        err;
        logic [31:0] rd;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] model [256];

    always @(negedge HCLK) begin
        if (rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rsp_extra: got rdata %h err %b want no response", rsp_rdata, rsp_err);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
                chk("rsp_rdata", rsp_rdata, e.rd);
            end
        end
    end

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic [2:0]  burst;
    } bus_t;

    bus_t bus_log [$];
    bit   log_en = 1'b0;

    always @(negedge HCLK) begin
        if (log_en && HTRANS[1] && HREADY) bus_log.push_back('{HADDR, HTRANS, HBURST});
    end

    task automatic issue(input bit w, input logic [31:0] a, input logic [2:0] sz,
                         input logic [31:0] d, input bit e, input logic [31:0] rd);
        int n = 0;
        @(negedge HCLK);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_size  = sz;
        req_wdata = d;
        while (!req_ready && n < 50) begin
            @(negedge HCLK);
            n++;
        end
        if (!req_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got ready 0 want 1 at addr %h", a);
            req_valid = 1'b0;
        end else begin
            sb.push_back('{e, rd});
            if (w && !e) model[a[9:2]] = d;
            @(posedge HCLK);
            #1;
        end
    endtask

    task automatic drop();
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge HCLK);
            n++;
        end
        chk("drain_pending", sb.size(), 0);
    endtask

    typedef struct packed {
        logic        w;
        logic [31:0] a;
        logic [2:0]  sz;
        logic [31:0] d;
        logic [31:0] rd;
        logic        seq;
    } vec_t;

    vec_t vec [8];

    initial begin
        int c0, c1;
        logic [1:0] et;

        vec[0] = '{1'b1, 32'h00, 3'd2, 32'h1111_1111, 32'h0, 1'b0};
        vec[1] = '{1'b1, 32'h04, 3'd2, 32'h2222_2222, 32'h0, 1'b1};
        vec[2] = '{1'b1, 32'h08, 3'd2, 32'h3333_3333, 32'h0, 1'b1};
        vec[3] = '{1'b1, 32'h0C, 3'd2, 32'h4444_4444, 32'h0, 1'b1};
        vec[4] = '{1'b0, 32'h00, 3'd2, 32'h0, 32'h1111_1111, 1'b0};
        vec[5] = '{1'b0, 32'h04, 3'd2, 32'h0, 32'h2222_2222, 1'b1};
        vec[6] = '{1'b0, 32'h0C, 3'd2, 32'h0, 32'h4444_4444, 1'b0};
        vec[7] = '{1'b0, 32'h08, 3'd2, 32'h0, 32'h3333_3333, 1'b0};

        for (int i = 0; i < 256; i++) model[i] = 32'hA500_0000 | i;
        model[16] = 32'hDEAD_BEEF;

        HRESET    = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 32'h0;
        req_size  = 3'd0;
        req_wdata = 32'h0;

        // reset state
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        chk("rst_htrans", {30'h0, HTRANS}, 32'h0);
        chk("rst_haddr", HADDR, 32'h0);
        chk("rst_hwrite", {31'h0, HWRITE}, 32'h0);
        chk("rst_hsize", {29'h0, HSIZE}, 32'h0);
        chk("rst_hburst", {29'h0, HBURST}, 32'h0);
        chk("rst_hwdata", HWDATA, 32'h0);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
        chk("rst_idle", {31'h0, idle}, 32'h1);
        chk("rst_req_ready", {31'h0, req_ready}, 32'h0);
        @(posedge HCLK);
        #1 HRESET = 1'b0;

        // single read, zero waits
        issue(1'b0, 32'h40, 3'd2, 32'h0, 1'b0, 32'hDEAD_BEEF);
        drop();
        @(negedge HCLK);
        chk("rd_htrans", {30'h0, HTRANS}, 32'h2);
        chk("rd_haddr", HADDR, 32'h40);
        chk("rd_hburst", {29'h0, HBURST}, {29'h0, EXP_BURST});
        chk("rd_hprot", {28'h0, HPROT}, 32'h3);
        chk("rd_hmastlock", {31'h0, HMASTLOCK}, 32'h0);
        chk("rd_rsp_early", {31'h0, rsp_valid}, 32'h0);
        @(negedge HCLK);
        chk("rd_htrans_idle", {30'h0, HTRANS}, 32'h0);
        chk("rd_idle_busy", {31'h0, idle}, 32'h0);
        @(negedge HCLK);
        chk("rd_rsp_valid", {31'h0, rsp_valid}, 32'h1);
        chk("rd_idle_after", {31'h0, idle}, 32'h1);
        drain();

        // back-to-back table
        log_en = 1'b1;
        bus_log.delete();
        c0 = 0;
        for (int i = 0; i < 8; i++) begin
            issue(vec[i].w, vec[i].a, vec[i].sz, vec[i].d, 1'b0, vec[i].rd);
            if (i == 0) c0 = cyc;
        end
        c1 = cyc;
        drop();
        chk("throughput", c1 - c0, 7);
        drain();
        log_en = 1'b0;
        chk("bus_count", bus_log.size(), 8);
        for (int i = 0; i < 8 && i < bus_log.size(); i++) begin
            et = (SEQ_BUILD && vec[i].seq) ? 2'b11 : 2'b10;
            chk("tbl_haddr", bus_log[i].addr, vec[i].a);
            chk("tbl_htrans", {30'h0, bus_log[i].trans}, {30'h0, et});
            chk("tbl_hburst", {29'h0, bus_log[i].burst}, {29'h0, EXP_BURST});
        end

        // two wait states on a read, follower held on the bus
        wait_addr = 32'h80;
        wait_cnt  = 2;
        issue(1'b0, 32'h80, 3'd2, 32'h0, 1'b0, model[32]);
        issue(1'b0, 32'h84, 3'd2, 32'h0, 1'b0, model[33]);
        drop();
        et = SEQ_BUILD ? 2'b11 : 2'b10;
        repeat (2) begin
            @(negedge HCLK);
            chk("ws_haddr", HADDR, 32'h84);
            chk("ws_htrans", {30'h0, HTRANS}, {30'h0, et});
            chk("ws_req_ready", {31'h0, req_ready}, 32'h0);
        end
        @(negedge HCLK);
        chk("ws_rsp_late", {31'h0, rsp_valid}, 32'h0);
        @(negedge HCLK);
        chk("ws_rsp_valid", {31'h0, rsp_valid}, 32'h1);
        drain();
        wait_addr = 32'hFFFF_FFFF;

        // ERROR on a write, pipelined read gets cancelled
        err_addr = 32'h100;
        issue(1'b1, 32'h100, 3'd2, 32'hCAFE_F00D, 1'b1, 32'h0);
        issue(1'b0, 32'h104, 3'd2, 32'h0, 1'b1, 32'h0);
        drop();
        @(negedge HCLK);
        chk("err1_hresp", {31'h0, HRESP}, 32'h1);
        chk("err1_htrans", {30'h0, HTRANS}, 32'h2);
        chk("err1_req_ready", {31'h0, req_ready}, 32'h0);
        @(negedge HCLK);
        chk("err2_htrans", {30'h0, HTRANS}, 32'h0);
        chk("err2_req_ready", {31'h0, req_ready}, 32'h0);
        @(negedge HCLK);
        chk("err_w_rsp", {31'h0, rsp_valid}, 32'h1);
        @(negedge HCLK);
        chk("err_r_rsp", {31'h0, rsp_valid}, 32'h1);
        drain();
        chk("err_read_on_bus", seen104, 0);
        err_addr = 32'hFFFF_FFFF;
        issue(1'b0, 32'h100, 3'd2, 32'h0, 1'b0, model[64]);
        drop();
        drain();

        // 1 KB boundary with halfwords
        issue(1'b0, 32'h3FE, 3'd1, 32'h0, 1'b0, model[255]);
        issue(1'b0, 32'h400, 3'd1, 32'h0, 1'b0, model[0]);
        drop();
        @(negedge HCLK);
        chk("kb_haddr", HADDR, 32'h400);
        chk("kb_htrans", {30'h0, HTRANS}, 32'h2);
        drain();

        // reset with AP and DP both occupied
        issue(1'b0, 32'h40, 3'd2, 32'h0, 1'b0, 32'hDEAD_BEEF);
        issue(1'b0, 32'h44, 3'd2, 32'h0, 1'b0, model[17]);
        drop();
        HRESET = 1'b1;
        @(negedge HCLK);
        chk("mr_req_ready", {31'h0, req_ready}, 32'h0);
        chk("mr_idle_before", {31'h0, idle}, 32'h0);
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        sb.delete();
        @(negedge HCLK);
        chk("mr_htrans", {30'h0, HTRANS}, 32'h0);
        chk("mr_idle", {31'h0, idle}, 32'h1);
        chk("mr_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        @(negedge HCLK);
        chk("mr_rsp_valid2", {31'h0, rsp_valid}, 32'h0);
        issue(1'b0, 32'h44, 3'd2, 32'h0, 1'b0, model[17]);
        drop();
        drain();

        repeat (3) @(negedge HCLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
